// File: rtl/fft_seq_ctrl.sv
// Sequencer for an FFT coprocessor attached to a CPU decode stage: accepts the
// LOAD / RUN / EXPORT instruction group, steps butterfly stages and stalls the CPU while busy.
module fft_seq_ctrl #(
    parameter int         NPTS        = 8,
    parameter int         STAGE_CYC   = 2,
    parameter int         LGN         = $clog2(NPTS),
    parameter logic [2:0] ALUOP_RTYPE = 3'b010
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue,
    input  logic [2:0]     aluop,
    input  logic [2:0]     funct3,
    input  logic [6:0]     funct7,
    input  logic [7:0]     idx_in,
    output logic           stall,
    output logic           ld_en,
    output logic           ex_en,
    output logic           ex_imag,
    output logic [LGN-1:0] elem_idx,
    output logic           stage_start,
    output logic [LGN-1:0] stage_idx,
    output logic           inverse,
    output logic           busy,
    output logic           done,
    output logic           err
);

    // state | meaning
    // IDLE  | waiting for a command; every FFT command is accepted here
    // RUN   | stepping LGN stages of STAGE_CYC cycles each; FFT commands stall
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0]     F7_LOAD  = 7'h10;
    localparam logic [6:0]     F7_FFT   = 7'h18;
    localparam logic [6:0]     F7_IFFT  = 7'h19;
    localparam logic [6:0]     F7_EXR   = 7'h1B;
    localparam logic [6:0]     F7_EXI   = 7'h1C;
    localparam logic [7:0]     NPTS_B   = 8'(NPTS);
    localparam logic [3:0]     CYC_LAST = 4'(STAGE_CYC - 1);
    localparam logic [LGN-1:0] STG_LAST = LGN'(LGN - 1);

    state_t     state;
    logic [3:0] cyc_cnt;
    logic       is_fft;
    logic       accept;
    logic       idx_ok;

    always_comb begin
        is_fft = 1'b0;
        if (issue && aluop == ALUOP_RTYPE && funct3 == 3'd0) begin
            is_fft = (funct7 == F7_LOAD) || (funct7 == F7_FFT) || (funct7 == F7_IFFT) ||
                     (funct7 == F7_EXR)  || (funct7 == F7_EXI);
        end
        accept = is_fft && (state == IDLE);
        idx_ok = (idx_in < NPTS_B);
        stall  = is_fft && (state == RUN) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            ld_en       <= 1'b0;
            ex_en       <= 1'b0;
            ex_imag     <= 1'b0;
            elem_idx    <= '0;
            stage_start <= 1'b0;
            stage_idx   <= '0;
            inverse     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ld_en       <= 1'b0;
            ex_en       <= 1'b0;
            ex_imag     <= 1'b0;
            stage_start <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (funct7 == F7_FFT || funct7 == F7_IFFT) begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            inverse     <= (funct7 == F7_IFFT);
                            cyc_cnt     <= '0;
                            stage_idx   <= '0;
                            stage_start <= 1'b1;
                        end else if (idx_ok) begin
                            elem_idx <= idx_in[LGN-1:0];
                            ld_en    <= (funct7 == F7_LOAD);
                            ex_en    <= (funct7 != F7_LOAD);
                            ex_imag  <= (funct7 == F7_EXI);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (stage_idx == STG_LAST) begin
                            // last cycle of last stage: next cycle is IDLE and can accept
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stage_idx <= '0;
                        end else begin
                            stage_idx   <= stage_idx + 1'b1;
                            stage_start <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: directed scenarios plus random traffic
// compared against a run-length/arithmetic reference model.
module tb_fft_seq_ctrl;

    localparam int         NPTS  = 8;
    localparam int         SC    = 2;
    localparam int         LG    = 3;
    localparam int         RUN_LEN = LG * SC;
    localparam logic [2:0] RTYPE = 3'b010;

    logic       clk = 1'b0;
    logic       rst, issue;
    logic [2:0] aluop, funct3;
    logic [6:0] funct7;
    logic [7:0] idx_in;

    logic       stall, ld_en, ex_en, ex_imag, stage_start, inverse, busy, done, err;
    logic [2:0] elem_idx, stage_idx;

    logic       stall_b, ld_en_b, ex_en_b, ex_imag_b, stage_start_b, inverse_b, busy_b, done_b, err_b;
    logic [5:0] elem_idx_b, stage_idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_stall, exp_stall;
    logic [13:0] obs_regs, exp_regs;

    int         m_k;
    logic       m_inv;
    logic [2:0] m_eidx;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.NPTS(8), .STAGE_CYC(2), .ALUOP_RTYPE(RTYPE)) dut (
        .clk(clk), .rst(rst), .issue(issue), .aluop(aluop), .funct3(funct3),
        .funct7(funct7), .idx_in(idx_in), .stall(stall), .ld_en(ld_en), .ex_en(ex_en),
        .ex_imag(ex_imag), .elem_idx(elem_idx), .stage_start(stage_start),
        .stage_idx(stage_idx), .inverse(inverse), .busy(busy), .done(done), .err(err)
    );

    fft_seq_ctrl #(.NPTS(64), .STAGE_CYC(1), .ALUOP_RTYPE(RTYPE)) dut64 (
        .clk(clk), .rst(rst), .issue(issue), .aluop(aluop), .funct3(funct3),
        .funct7(funct7), .idx_in(idx_in), .stall(stall_b), .ld_en(ld_en_b), .ex_en(ex_en_b),
        .ex_imag(ex_imag_b), .elem_idx(elem_idx_b), .stage_start(stage_start_b),
        .stage_idx(stage_idx_b), .inverse(inverse_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Drive one cycle of inputs, capture stall, advance the model, then capture registered outputs.
    task automatic apply(input logic r, input logic iss, input logic [2:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [7:0] idx);
        logic cmd;
        logic e_ld, e_ex, e_im, e_ss, e_busy, e_done, e_err;
        int   e_sidx;
        rst = r; issue = iss; aluop = op; funct3 = f3; funct7 = f7; idx_in = idx;
        #2;
        obs_stall = stall;
        cmd = iss && (op == RTYPE) && (f3 == 3'd0) &&
              (f7 inside {7'h10, 7'h18, 7'h19, 7'h1B, 7'h1C});
        exp_stall = cmd && (m_k >= 0) && !r;
        {e_ld, e_ex, e_im, e_ss, e_busy, e_done, e_err} = '0;
        e_sidx = 0;
        if (r) begin
            m_k = -1; m_inv = 1'b0; m_eidx = '0;
        end else if (m_k >= 0) begin
            if (m_k + 1 == RUN_LEN) begin
                m_k = -1; e_done = 1'b1;
            end else begin
                m_k++;
                e_busy = 1'b1;
                e_sidx = m_k / SC;
                e_ss   = (m_k % SC) == 0;
            end
        end else if (cmd) begin
            if (f7 == 7'h18 || f7 == 7'h19) begin
                m_k = 0; e_busy = 1'b1; e_ss = 1'b1; m_inv = (f7 == 7'h19);
            end else if (int'(idx) < NPTS) begin
                m_eidx = idx[2:0];
                e_ld = (f7 == 7'h10);
                e_ex = !e_ld;
                e_im = (f7 == 7'h1C);
            end else begin
                e_err = 1'b1;
            end
        end
        exp_regs = {e_ld, e_ex, e_im, m_eidx, e_ss, 3'(e_sidx), m_inv, e_busy, e_done, e_err};
        @(posedge clk); #1;
        obs_regs = {ld_en, ex_en, ex_imag, elem_idx, stage_start, stage_idx, inverse, busy, done, err};
    endtask

    task automatic idle_cycle();
        apply(1'b0, 1'b0, 3'd0, 3'd0, 7'h00, 8'd0);
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'd0);
        n_checks++;
        if (obs_regs !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_regs);
        end
        // start a run, then reset while a stalled command is presented
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h18, 8'd0);
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h1B, 8'd1);
        n_checks++;
        if (obs_stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_stall: got %b want 1", obs_stall);
        end
        apply(1'b1, 1'b1, RTYPE, 3'd0, 7'h1B, 8'd1);
        n_checks++;
        if (obs_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_low: got %b want 0", obs_stall);
        end
        n_checks++;
        if (obs_regs !== 14'd0 || obs_regs !== exp_regs) begin
            n_fail++; $display("FAIL reset_in_run: got %h want 0", obs_regs);
        end
    endtask

    task automatic test_load_export();
        // {funct7, idx}: valid load, out-of-range load, exports, ignored ADD, wrong funct3
        logic [6:0] f7s [6] = '{7'h10, 7'h10, 7'h1B, 7'h1C, 7'h00, 7'h10};
        logic [7:0] ids [6] = '{8'd5, 8'd9, 8'd7, 8'd0, 8'd2, 8'd3};
        logic [2:0] f3s [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, RTYPE, f3s[i], f7s[i], ids[i]);
            n_checks++;
            if (obs_stall !== exp_stall) begin
                n_fail++; $display("FAIL ldex_stall[%0d]: got %b want %b", i, obs_stall, exp_stall);
            end
            n_checks++;
            if (obs_regs !== exp_regs) begin
                n_fail++; $display("FAIL ldex_regs[%0d]: got %h want %h", i, obs_regs, exp_regs);
            end
        end
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h10, 8'd5);
        n_checks++;
        if ({obs_stall, obs_regs[13], obs_regs[10:8]} !== {1'b0, 1'b1, 3'd5}) begin
            n_fail++; $display("FAIL load5_direct: got %h want ld_en=1 idx=5", obs_regs);
        end
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h10, 8'd9);
        n_checks++;
        if ({obs_regs[13], obs_regs[0]} !== 2'b01) begin
            n_fail++; $display("FAIL load9_err: got %h want err=1 ld_en=0", obs_regs);
        end
    endtask

    task automatic test_run_fft();
        int stalls;
        bit accepted;
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h18, 8'd0);
        n_checks++;
        if (obs_regs !== exp_regs) begin
            n_fail++; $display("FAIL run_start: got %h want %h", obs_regs, exp_regs);
        end
        idle_cycle();
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h00, 8'd0);
        n_checks++;
        if (obs_stall !== 1'b0) begin
            n_fail++; $display("FAIL add_in_run_stall: got %b want 0", obs_stall);
        end
        stalls = 0;
        accepted = 0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h1C, 8'd4);
            n_checks++;
            if (obs_regs !== exp_regs || obs_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL run_cycle[%0d]: got %b/%h want %b/%h", c, obs_stall, obs_regs, exp_stall, exp_regs);
            end
            if (obs_stall) stalls++;
            else accepted = 1;
        end
        n_checks++;
        if (!accepted || stalls != 4) begin
            n_fail++; $display("FAIL export_stall_count: got %0d want 4", stalls);
        end
        n_checks++;
        if ({obs_regs[12:8], obs_regs[3]} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
            n_fail++; $display("FAIL export_imag_after_run: got %h want ex_en/ex_imag=1 idx=4 inv=0", obs_regs);
        end
    endtask

    task automatic test_run_reset();
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h19, 8'd0);
        n_checks++;
        if (obs_regs[3] !== 1'b1) begin
            n_fail++; $display("FAIL ifft_inverse: got %b want 1", obs_regs[3]);
        end
        idle_cycle();
        idle_cycle();
        apply(1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'd0);
        n_checks++;
        if (obs_regs !== 14'd0) begin
            n_fail++; $display("FAIL abort_outputs: got %h want 0", obs_regs);
        end
        for (int c = 0; c < 8; c++) begin
            idle_cycle();
            n_checks++;
            if (obs_regs !== exp_regs || done !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_done[%0d]: got %h want %h", c, obs_regs, exp_regs);
            end
        end
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h10, 8'd3);
        n_checks++;
        if (obs_regs !== exp_regs || ld_en !== 1'b1) begin
            n_fail++; $display("FAIL load_after_abort: got %h want %h", obs_regs, exp_regs);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] f7s [4] = '{7'h10, 7'h1B, 7'h1C, 7'h10};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, RTYPE, 3'd0, f7s[i], 8'(i + 1));
            n_checks++;
            if (obs_regs !== exp_regs || obs_stall !== 1'b0 || elem_idx !== 3'(i + 1)) begin
                n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, obs_regs, exp_regs);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] f7pool [7] = '{7'h10, 7'h18, 7'h19, 7'h1B, 7'h1C, 7'h00, 7'h11};
        logic       r, iss;
        logic [2:0] op, f3;
        logic [6:0] f7;
        logic [7:0] idx;
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(63) == 0);
            iss = ($urandom_range(3) != 0);
            op  = ($urandom_range(3) != 0) ? RTYPE : 3'($urandom_range(7));
            f3  = ($urandom_range(7) != 0) ? 3'd0 : 3'($urandom_range(7));
            f7  = f7pool[$urandom_range(6)];
            idx = ($urandom_range(3) != 0) ? 8'($urandom_range(11)) : 8'($urandom_range(255));
            apply(r, iss, op, f3, f7, idx);
            n_checks++;
            if (obs_stall !== exp_stall) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", c, obs_stall, exp_stall);
            end
            n_checks++;
            if (obs_regs !== exp_regs) begin
                n_fail++; $display("FAIL rand_regs[%0d]: got %h want %h", c, obs_regs, exp_regs);
            end
        end
    endtask

    task automatic test_run64();
        apply(1'b1, 1'b0, 3'd0, 3'd0, 7'h00, 8'd0);
        apply(1'b0, 1'b1, RTYPE, 3'd0, 7'h18, 8'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) idle_cycle();
            n_checks++;
            if ({busy_b, done_b, stage_start_b, stage_idx_b} !== {1'b1, 1'b0, 1'b1, 6'(i)}) begin
                n_fail++;
                $display("FAIL run64_stage[%0d]: got busy=%b done=%b ss=%b idx=%0d want 1/0/1/%0d",
                         i, busy_b, done_b, stage_start_b, stage_idx_b, i);
            end
        end
        idle_cycle();
        n_checks++;
        if ({busy_b, done_b, stage_idx_b} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL run64_done: got busy=%b done=%b idx=%0d want 0/1/0", busy_b, done_b, stage_idx_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_k = -1; m_inv = 1'b0; m_eidx = '0;
        rst = 1'b1; issue = 1'b0; aluop = '0; funct3 = '0; funct7 = '0; idx_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_load_export();
        test_run_fft();
        test_run_reset();
        test_back_to_back();
        test_run64();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter NPTS, default 8, meaning FFT point count; power of two, 4..64.
REQ-002 Parameter STAGE_CYC, default 2, meaning cycles per butterfly stage; range 1..15.
REQ-003 Parameter LGN, default log2(NPTS), meaning stage count and index width; derived, not user-set.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 issue  input  1  decoded instruction valid this cycle.
REQ-007 aluop  input  3  decoder ALU class; the FFT group is under R-type.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7  input  7  instruction funct7.
REQ-010 idx_in  input  8  element index from rs2[7:0].
REQ-011 stall  output  1  hold the pipeline, combinational.
REQ-012 ld_en, ex_en  output  1 each  load / export strobe, registered.
REQ-013 ex_imag  output  1  export selects the imaginary part.
REQ-014 elem_idx  output  LGN  element index for load/export.
REQ-015 stage_start  output  1  pulse at the first cycle of each stage.
REQ-016 stage_idx  output  LGN  current stage number.
REQ-017 inverse  output  1  current or last run is IFFT.
REQ-018 busy, done, err  output  1 each  running / completion pulse / illegal-command pulse.

Function
REQ-019 FFT command = issue & aluop==R-type & funct3==0 & funct7 in {10h,18h,19h,1Bh,1Ch}; all other instructions are ignored and never stall.
REQ-020 Command decode: 10h LOAD[idx]; 18h RUN-FFT; 19h RUN-IFFT; 1Bh EXPORT-REAL[idx]; 1Ch EXPORT-IMAG[idx].
REQ-021 FSM states are IDLE and RUN; a command is accepted only in IDLE.
REQ-022 stall = FFT command & state==RUN; a stalled command is re-presented by the CPU and is not latched.
REQ-023 Accepted LOAD or EXPORT with idx_in < NPTS asserts ld_en or ex_en for exactly one cycle, in the cycle after acceptance, with elem_idx = idx_in[LGN-1:0]; ex_imag = 1 only for 1Ch.
REQ-024 Accepted LOAD or EXPORT with idx_in >= NPTS produces no strobe and a one-cycle err pulse in the next cycle.
REQ-025 Accepted RUN: the next cycle enters RUN with busy=1 and inverse = (funct7==19h); the CPU is not stalled by the RUN command itself.
REQ-026 In RUN, the cycle counter counts 0..STAGE_CYC-1 per stage and stage_idx counts 0..LGN-1; stage_start=1 when the cycle count is 0.
REQ-027 RUN lasts exactly LGN*STAGE_CYC cycles; the following cycle is IDLE with done=1 for one cycle, busy=0, and a new command is accepted in that cycle.
REQ-028 inverse holds its value after the run until the next accepted RUN.
REQ-029 stage_idx and the cycle counter return to 0 on leaving RUN; no wrap beyond LGN-1.
REQ-030 Back-to-back commands in IDLE are accepted on consecutive cycles; strobes pipeline one cycle behind.

Reset
REQ-031 rst sampled high forces IDLE, clears all counters, and drives ld_en, ex_en, ex_imag, elem_idx, stage_start, stage_idx, inverse, busy, done and err to 0 on the next edge.
REQ-032 rst during RUN aborts the run without a done pulse; the first command after rst deasserts is accepted normally.
REQ-033 stall is 0 while rst is high.

Verification
REQ-034 NPTS=8: LOAD idx 5 at cycle t -> ld_en=1, elem_idx=5 at t+1, stall=0.
REQ-035 NPTS=8, STAGE_CYC=2: RUN-FFT at t -> busy for t+1..t+6, stage_start at t+1/t+3/t+5 with stage_idx 0/1/2, done at t+7, inverse=0.
REQ-036 EXPORT-IMAG issued at t+3 during a run -> stall=1 through t+6, accepted at t+7, ex_en=1 with ex_imag=1 at t+8.
REQ-037 LOAD idx 9 with NPTS=8 -> err=1 next cycle, ld_en=0; ADD (funct7=00h) in RUN -> stall=0.
REQ-038 RUN-IFFT, then rst at the 3rd RUN cycle -> all outputs 0 the next cycle, no done pulse; a LOAD issued after rst deasserts is accepted.
REQ-039 NPTS=64, STAGE_CYC=1: RUN -> 6 busy cycles with stage_idx 0..5, then done.
